// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: control-bit layouts, pc-select encoding and MEM-stage FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regidx_t;

    // Field order is MSB first, so dren lands on bit 0.
    typedef struct packed {
        logic jmp;
        logic bne;
        logic beq;
        logic dwen;
        logic dren;
    } memctrl_t;

    typedef struct packed {
        logic       halt;
        logic [1:0] wsel;
        logic       regwen;
    } wbctrl_t;

    typedef enum logic [1:0] {
        PC_NPC = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pcsel_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_WAIT = 2'b01,
        M_DONE = 2'b10
    } memstate_t;

endpackage

// File: rtl/memwb_if.sv
// MEM/WB latch signals; rf is the writeback/regfile consumer, tb an observer.
interface memwb_if #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    logic [WORD_W-1:0] wb_aluout;
    logic [WORD_W-1:0] wb_load;
    logic [WORD_W-1:0] wb_npc;
    logic [REG_W-1:0]  wb_dest;
    logic [3:0]        wb_WBctrl;

    modport rf (input wb_aluout, wb_load, wb_npc, wb_dest, wb_WBctrl);
    modport tb (input wb_aluout, wb_load, wb_npc, wb_dest, wb_WBctrl);
endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: loads its payload when enabled, holds otherwise.
module memwb_reg #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_aluout,
    input  logic [WORD_W-1:0] i_load,
    input  logic [WORD_W-1:0] i_npc,
    input  logic [REG_W-1:0]  i_dest,
    input  logic [3:0]        i_wbctrl,
    output logic [WORD_W-1:0] o_aluout,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_npc,
    output logic [REG_W-1:0]  o_dest,
    output logic [3:0]        o_wbctrl
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_aluout <= '0;
            o_load   <= '0;
            o_npc    <= '0;
            o_dest   <= '0;
            o_wbctrl <= '0;
        end else if (i_en) begin
            o_aluout <= i_aluout;
            o_load   <= i_load;
            o_npc    <= i_npc;
            o_dest   <= i_dest;
            o_wbctrl <= i_wbctrl;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: dcache request/stall FSM, branch/jump resolution and the MEM/WB latch.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] aluout_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [WORD_W-1:0] baddr_in,
    input  logic [WORD_W-1:0] jaddr_in,
    input  logic              zero_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [3:0]        WBctrl_in,
    input  logic [4:0]        MEMctrl_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [1:0]        pcsel,
    output logic [WORD_W-1:0] pc_target,
    output logic              flush,
    output logic [WORD_W-1:0] wb_aluout,
    output logic [WORD_W-1:0] wb_load,
    output logic [WORD_W-1:0] wb_npc,
    output logic [REG_W-1:0]  wb_dest,
    output logic [3:0]        wb_WBctrl,
    output logic              halt
);
    memctrl_t          w_mc;
    memstate_t         r_state, w_next;
    logic [WORD_W-1:0] r_ldbuf;
    logic              r_halt;
    logic              w_memop, w_active, w_stall, w_adv, w_taken, w_wb_en;
    logic [WORD_W-1:0] w_load_sel;
    pcsel_t            w_pcsel;
    logic [WORD_W-1:0] w_target;

    assign w_mc     = MEMctrl_in;
    assign w_memop  = w_mc.dren | w_mc.dwen;
    // Once the access has completed (M_DONE) the request is dropped while we wait for ihit.
    assign w_active = w_memop & (r_state != M_DONE);
    assign w_stall  = w_active & ~dhit;
    assign w_adv    = ihit & ~w_stall;
    assign w_wb_en  = w_adv & ~r_halt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            M_IDLE: if (w_memop) begin
                if (!dhit)      w_next = M_WAIT;
                else if (!w_adv) w_next = M_DONE;
            end
            M_WAIT: if (dhit)   w_next = w_adv ? M_IDLE : M_DONE;
            M_DONE: if (w_adv)  w_next = M_IDLE;
            default:            w_next = M_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= M_IDLE;
            r_ldbuf <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_active && dhit) r_ldbuf <= dmemload;
            if (w_wb_en && WBctrl_in[3]) r_halt <= 1'b1;
        end
    end

    assign w_load_sel = dhit ? dmemload : r_ldbuf;

    assign w_taken = (w_mc.beq & zero_in) | (w_mc.bne & ~zero_in);

    always_comb begin
        w_pcsel  = PC_NPC;
        w_target = npc_in;
        if (w_mc.jmp) begin
            w_pcsel  = PC_JMP;
            w_target = jaddr_in;
        end else if (w_taken) begin
            w_pcsel  = PC_BR;
            w_target = baddr_in;
        end
    end

    // Bus outputs are forced low asynchronously so a reset kills an in-flight request.
    assign dmemREN   = ~RST & w_active & w_mc.dren & ~w_mc.dwen;
    assign dmemWEN   = ~RST & w_active & w_mc.dwen;
    assign dmemaddr  = RST ? '0 : aluout_in;
    assign dmemstore = RST ? '0 : store_in;
    assign mem_stall = ~RST & w_stall;
    assign pcsel     = RST ? 2'b00 : w_pcsel;
    assign pc_target = RST ? '0 : w_target;
    assign flush     = ~RST & (w_taken | w_mc.jmp) & w_adv;
    assign halt      = r_halt;

    memwb_if #(.WORD_W(WORD_W), .REG_W(REG_W)) mw ();

    memwb_reg #(.WORD_W(WORD_W), .REG_W(REG_W)) u_memwb (
        .CLK      (CLK),
        .RST      (RST),
        .i_en     (w_wb_en),
        .i_aluout (aluout_in),
        .i_load   (w_load_sel),
        .i_npc    (npc_in),
        .i_dest   (dest_in),
        .i_wbctrl (WBctrl_in),
        .o_aluout (mw.wb_aluout),
        .o_load   (mw.wb_load),
        .o_npc    (mw.wb_npc),
        .o_dest   (mw.wb_dest),
        .o_wbctrl (mw.wb_WBctrl)
    );

    assign wb_aluout = mw.wb_aluout;
    assign wb_load   = mw.wb_load;
    assign wb_npc    = mw.wb_npc;
    assign wb_dest   = mw.wb_dest;
    assign wb_WBctrl = mw.wb_WBctrl;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined MIPS datapath. Sits directly downstream of the EX/MEM latch and consumes its outputs.
- Issues the data-cache request and holds the pipeline until the request completes.
- Resolves branches and jumps, and drives a pc-select/flush to fetch.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
- WORD_W, 32, datapath word width (matches word_t).
- REG_W, 5, register index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  icache hit; global pipeline-advance enable.
- aluout_in  in  32  EX/MEM ALU result; also the data address.
- store_in  in  32  EX/MEM store data.
- npc_in  in  32  EX/MEM PC+4.
- baddr_in  in  32  branch target.
- jaddr_in  in  32  J/JAL/JR target, already muxed in EX.
- zero_in  in  1  ALU zero flag.
- dest_in  in  5  destination register.
- WBctrl_in  in  4  writeback control bits.
- MEMctrl_in  in  5  memory/branch control bits.
- dhit  in  1  dcache hit/done.
- dmemload  in  32  dcache read data.
- dmemREN  out  1  dcache read request.
- dmemWEN  out  1  dcache write request.
- dmemaddr  out  32  dcache address.
- dmemstore  out  32  dcache write data.
- mem_stall  out  1  holds all upstream latches and PC.
- pcsel  out  2  00 = npc, 01 = branch, 10 = jump.
- pc_target  out  32  selected redirect target.
- flush  out  1  squash IF/ID and ID/EX.
- wb_aluout, wb_load, wb_npc  out  32 each  MEM/WB payload.
- wb_dest  out  5  MEM/WB destination.
- wb_WBctrl  out  4  MEM/WB writeback control.
- halt  out  1  sticky halt to the system.

Behaviour:
- MEMctrl bits: [0] dREN, [1] dWEN, [2] BEQ, [3] BNE, [4] JMP.
- WBctrl bits: [0] RegWEN, [2:1] wsel (00 alu, 01 load, 10 npc), [3] HALT.
- memop = MEMctrl[0] | MEMctrl[1]. dREN and dWEN both set is illegal; treat it as a write.
- FSM states: M_IDLE, M_WAIT, M_DONE. Reset state is M_IDLE.
  - M_IDLE: if memop and no dhit, go to M_WAIT. If memop and dhit in the same cycle, go to M_DONE unless the stage advances that cycle.
  - M_WAIT: stay until dhit. On dhit, capture dmemload into the load buffer. Go to M_IDLE if the stage advances that cycle, else M_DONE.
  - M_DONE: drop the request and hold the buffered data. Go to M_IDLE on advance.
- Request: dmemREN/dmemWEN follow MEMctrl while memop and state != M_DONE. dmemaddr = aluout_in. dmemstore = store_in.
- mem_stall = memop & ~dhit & (state != M_DONE). This is combinational.
- advance = ihit & ~mem_stall.
- Load data select: dmemload when dhit is high this cycle, else the buffered value.
- Branch/jump resolution is combinational from EX/MEM:
  - taken = (BEQ & zero) | (BNE & ~zero).
  - JMP has priority over branches: pcsel = 10, pc_target = jaddr_in.
  - taken: pcsel = 01, pc_target = baddr_in.
  - otherwise: pcsel = 00, pc_target = npc_in.
  - flush = (taken | JMP) & advance.
- MEM/WB register: loads on advance and holds otherwise. wb_load takes the selected load data.
- Reset: every MEM/WB output, halt, the load buffer and the FSM are 0 / M_IDLE. All bus outputs are 0 while RST is high.
- RST asserted during M_WAIT drops the request immediately and loses the pending transaction.
- halt sets when wb_WBctrl[3] is latched. It stays set until RST, and once set, further MEM/WB loads are blocked.
- A non-memop instruction never stalls, and its latency is 1 cycle to MEM/WB.
- Memop latency is 1 + (cycles to dhit), with no extra cycle when dhit arrives together with ihit.

Decomposition:
- cpu_types_pkg gains:
  - memctrl_t and wbctrl_t packed structs for the bit layouts above.
  - pcsel_t enum (PC_NPC, PC_BR, PC_JMP).
  - memstate_t enum (M_IDLE, M_WAIT, M_DONE).
- A new memwb_if interface carries the MEM/WB signals, with rf/tb modports mirroring the existing latch interfaces.
- One sub-module, memwb_reg, holds the MEM/WB register with an enable. It is instantiated inside mem_stage.

Test Plan:
- ALU op, no memop, ihit = 1, aluout = 0x0000_0010, dest = 5 -> next edge wb_aluout = 0x10, wb_dest = 5; mem_stall stays 0.
- LW to address 0x0000_0100, dhit held 0 for 3 cycles, then 1 with dmemload = 0xDEAD_BEEF, ihit = 1 -> mem_stall high for 3 cycles, dmemREN = 1, dmemaddr = 0x100; wb_load = 0xDEADBEEF one edge after dhit.
- SW with dhit on cycle 2 and ihit low until cycle 4 -> dmemWEN drops after dhit (M_DONE); MEM/WB loads at cycle 4; exactly one write request is issued.
- BEQ with zero = 1, baddr = 0x0000_0040, ihit = 1 -> pcsel = 01, pc_target = 0x40, flush = 1. The same with zero = 0 -> pcsel = 00, flush = 0. JMP together with BEQ taken -> pcsel = 10.
- HALT instruction latched -> halt = 1 and stays 1. A subsequent LW does not update wb_* outputs.
- RST pulsed mid-M_WAIT -> dmemREN falls without waiting for a clock edge; all wb_* outputs read 0 and the FSM returns to M_IDLE.
